// File: rtl/deck_pool_pkg.sv
// Shared types and helpers for the card pool: card encodings, FSM states,
// the power-up card layout and LFSR tap selection.
package deck_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2,
        BLUE   = 2'd3
    } color_e;

    localparam logic [3:0] VAL_SKIP    = 4'd10;
    localparam logic [3:0] VAL_REVERSE = 4'd11;
    localparam logic [3:0] VAL_DRAW2   = 4'd12;
    localparam logic [3:0] VAL_WILD    = 4'd13;
    localparam logic [3:0] VAL_WILD4   = 4'd14;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_SHUFFLE = 2'd2
    } state_e;

    // Layout entry i as {color, value}: each color block holds one 0, two of
    // each 1-9/SKIP/REVERSE/DRAW2, then one WILD and one WILD4.
    function automatic logic [5:0] init_card(input int i);
        int     k;
        color_e c;
        logic [3:0] v;
        if (i < 0 || i >= 108) begin
            return 6'd0;
        end
        c = color_e'(2'(i / 27));
        k = i % 27;
        if (k == 0) begin
            v = 4'd0;
        end else if (k <= 24) begin
            v = 4'((k + 1) / 2);
        end else if (k == 25) begin
            v = VAL_WILD;
        end else begin
            v = VAL_WILD4;
        end
        return {c, v};
    endfunction

    function automatic logic [31:0] fill_mask(input logic [31:0] v);
        logic [31:0] m;
        m = v;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        m = m | (m >> 16);
        return m;
    endfunction

    // Right-shifting Galois feedback masks; bit t-1 set for each tap t.
    function automatic logic [63:0] lfsr_taps(input int w);
        case (w)
            8:       return 64'h0000_0000_0000_00B8;
            16:      return 64'h0000_0000_0000_B400;
            24:      return 64'h0000_0000_00E1_0000;
            32:      return 64'h0000_0000_8020_0003;
            default: return (64'd1 << (w - 1)) | 64'd1;
        endcase
    endfunction

endpackage

// File: rtl/deck_pool_if.sv
// Command/response bundle between a card pool client (master) and deck_pool (slave).
interface deck_pool_if #(
    parameter int CARD_W = 6,
    parameter int IDX_W  = 7
);
    logic              reload;
    logic              shuffle;
    logic              draw_req;
    logic              insert_valid;
    logic [CARD_W-1:0] insert_card;
    logic              ready;
    logic              draw_valid;
    logic [CARD_W-1:0] draw_card;
    logic              draw_err;
    logic              insert_err;
    logic [IDX_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              shuffle_done;

    modport master (
        output reload, shuffle, draw_req, insert_valid, insert_card,
        input  ready, draw_valid, draw_card, draw_err, insert_err,
               count, empty, full, shuffle_done
    );

    modport slave (
        input  reload, shuffle, draw_req, insert_valid, insert_card,
        output ready, draw_valid, draw_card, draw_err, insert_err,
               count, empty, full, shuffle_done
    );
endinterface

// File: rtl/deck_pool_lfsr.sv
// Galois LFSR with synchronous load and step; exposes the low bits of the
// stepped value so the caller can use them in the same cycle.
module deck_lfsr
    import deck_pkg::*;
#(
    parameter int SEED_W = 16,
    parameter int OUT_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [SEED_W-1:0] seed_i,
    input  logic              step_i,
    output logic [OUT_W-1:0]  next_o
);
    localparam logic [SEED_W-1:0] TAPS = SEED_W'(lfsr_taps(SEED_W));

    logic [SEED_W-1:0] lfsr_q, lfsr_d, stepped;

    always_comb begin
        stepped = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        next_o  = stepped[OUT_W-1:0];
        lfsr_d  = lfsr_q;
        if (load_i) begin
            lfsr_d = seed_i;
        end else if (step_i) begin
            lfsr_d = stepped;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED_W'(1);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
endmodule

// File: rtl/deck_pool.sv
// Card pool: LIFO of cards with reload, draw/insert and an in-place
// Fisher-Yates shuffle. Define DECK_POOL_SEED_PORT_EN to seed shuffles from the seed port.
module deck_pool
    import deck_pkg::*;
#(
    parameter int DEPTH  = 108,
    parameter int CARD_W = 6,
    parameter int SEED_W = 16
) (
    input  logic              clk,
    input  logic              reset,
`ifdef DECK_POOL_SEED_PORT_EN
    input  logic [SEED_W-1:0] seed,
`endif
    deck_pool_if.slave        bus
);
    localparam int IDX_W = $clog2(DEPTH + 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  count_q, count_d, j_q, j_d;
    logic [SEED_W-1:0] freeCnt_q;
    logic              drawValid_q, drawValid_d, drawErr_q, drawErr_d;
    logic              insertErr_q, insertErr_d, shuffleDone_q, shuffleDone_d;
    logic [CARD_W-1:0] drawCard_q, drawCard_d;

    logic [CARD_W-1:0] mem [DEPTH];
    logic              wrEnA, wrEnB;
    logic [IDX_W-1:0]  wrAddrA, wrAddrB;
    logic [CARD_W-1:0] wrDataA, wrDataB;

    logic              lfsrLoad, lfsrStep;
    logic [IDX_W-1:0]  lfsrNext, randIdx, jMask, topIdx, countAfter;
    logic [SEED_W-1:0] seedSrc, seedVal;
    logic [5:0]        initRaw;
    logic [CARD_W-1:0] initCard;

`ifdef DECK_POOL_SEED_PORT_EN
    assign seedSrc = seed;
`else
    assign seedSrc = freeCnt_q;
`endif
    assign seedVal = (seedSrc == '0) ? SEED_W'(1) : seedSrc;

    deck_lfsr #(
        .SEED_W (SEED_W),
        .OUT_W  (IDX_W)
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .load_i (lfsrLoad),
        .seed_i (seedVal),
        .step_i (lfsrStep),
        .next_o (lfsrNext)
    );

    assign jMask   = IDX_W'(fill_mask(32'(j_q)));
    assign randIdx = lfsrNext & jMask;
    assign topIdx  = count_q - IDX_W'(1);

    // Wider cards keep color in the top two bits and zero-pad the value.
    always_comb begin
        initRaw  = init_card(int'(j_q));
        initCard = '0;
        initCard[CARD_W-1 -: 2] = initRaw[5:4];
        initCard[3:0]           = initRaw[3:0];
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        j_d           = j_q;
        drawCard_d    = drawCard_q;
        drawValid_d   = 1'b0;
        drawErr_d     = 1'b0;
        insertErr_d   = 1'b0;
        shuffleDone_d = 1'b0;
        wrEnA         = 1'b0;
        wrAddrA       = j_q;
        wrDataA       = initCard;
        wrEnB         = 1'b0;
        wrAddrB       = randIdx;
        wrDataB       = mem[j_q];
        lfsrLoad      = 1'b0;
        lfsrStep      = 1'b0;
        countAfter    = count_q;

        unique case (state_q)
            ST_INIT: begin
                wrEnA = 1'b1;
                if (j_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    count_d = IDX_W'(DEPTH);
                    j_d     = '0;
                end else begin
                    j_d = j_q + IDX_W'(1);
                end
            end

            ST_IDLE: begin
                if (bus.reload) begin
                    state_d = ST_INIT;
                    count_d = '0;
                    j_d     = '0;
                end else begin
                    // A combined draw+insert swaps the top card in place.
                    if (bus.draw_req) begin
                        if (count_q != '0) begin
                            drawValid_d = 1'b1;
                            drawCard_d  = mem[topIdx];
                            if (bus.insert_valid) begin
                                wrEnA   = 1'b1;
                                wrAddrA = topIdx;
                                wrDataA = bus.insert_card;
                            end else begin
                                countAfter = count_q - IDX_W'(1);
                            end
                        end else begin
                            drawErr_d = 1'b1;
                            if (bus.insert_valid) begin
                                wrEnA      = 1'b1;
                                wrAddrA    = '0;
                                wrDataA    = bus.insert_card;
                                countAfter = count_q + IDX_W'(1);
                            end
                        end
                    end else if (bus.insert_valid) begin
                        if (count_q != IDX_W'(DEPTH)) begin
                            wrEnA      = 1'b1;
                            wrAddrA    = count_q;
                            wrDataA    = bus.insert_card;
                            countAfter = count_q + IDX_W'(1);
                        end else begin
                            insertErr_d = 1'b1;
                        end
                    end
                    count_d = countAfter;

                    if (bus.shuffle) begin
                        if (countAfter <= IDX_W'(1)) begin
                            shuffleDone_d = 1'b1;
                        end else begin
                            lfsrLoad = 1'b1;
                            j_d      = countAfter - IDX_W'(1);
                            state_d  = ST_SHUFFLE;
                        end
                    end
                end
            end

            ST_SHUFFLE: begin
                lfsrStep = 1'b1;
                if (randIdx <= j_q) begin
                    wrEnA   = 1'b1;
                    wrAddrA = j_q;
                    wrDataA = mem[randIdx];
                    wrEnB   = 1'b1;
                    wrAddrB = randIdx;
                    wrDataB = mem[j_q];
                    j_d     = j_q - IDX_W'(1);
                    if (j_q == IDX_W'(1)) begin
                        shuffleDone_d = 1'b1;
                        state_d       = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_INIT;
                j_d     = '0;
            end
        endcase
    end

    // Card storage is deliberately unreset; INIT rewrites every entry.
    always_ff @(posedge clk) begin
        if (wrEnA) begin
            mem[wrAddrA] <= wrDataA;
        end
        if (wrEnB) begin
            mem[wrAddrB] <= wrDataB;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_INIT;
            count_q       <= '0;
            j_q           <= '0;
            freeCnt_q     <= '0;
            drawValid_q   <= 1'b0;
            drawErr_q     <= 1'b0;
            insertErr_q   <= 1'b0;
            shuffleDone_q <= 1'b0;
            drawCard_q    <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            j_q           <= j_d;
            freeCnt_q     <= freeCnt_q + SEED_W'(1);
            drawValid_q   <= drawValid_d;
            drawErr_q     <= drawErr_d;
            insertErr_q   <= insertErr_d;
            shuffleDone_q <= shuffleDone_d;
            drawCard_q    <= drawCard_d;
        end
    end

    assign bus.ready        = (state_q == ST_IDLE);
    assign bus.draw_valid   = drawValid_q;
    assign bus.draw_card    = drawCard_q;
    assign bus.draw_err     = drawErr_q;
    assign bus.insert_err   = insertErr_q;
    assign bus.shuffle_done = shuffleDone_q;
    assign bus.count        = count_q;
    assign bus.empty        = (count_q == '0);
    assign bus.full         = (count_q == IDX_W'(DEPTH));
endmodule

// File: tb/tb_deck_pool.sv
// Scoreboard bench for deck_pool: stimulus queues expected responses, a
// negedge monitor pops and compares every response pulse.
module tb_deck_pool;
    localparam int DEPTH  = 108;
    localparam int CARD_W = 6;
    localparam int SEED_W = 16;
    localparam int IDX_W  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              dv;
        logic              de;
        logic              ie;
        logic              sd;
        logic              anyCard;
        logic [CARD_W-1:0] card;
    } rsp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   nCycles;
    rsp_t expQ[$];
    rsp_t gotRsp, expRsp;
    logic [CARD_W-1:0] model[$];
    logic [CARD_W-1:0] gotCards[$];
    logic [CARD_W-1:0] firstShuffle[$];

    always #5 clk = ~clk;

    deck_pool_if #(.CARD_W(CARD_W), .IDX_W(IDX_W)) bus ();

`ifdef DECK_POOL_SEED_PORT_EN
    logic [SEED_W-1:0] seed = 16'hACE1;
`endif

    deck_pool #(
        .DEPTH  (DEPTH),
        .CARD_W (CARD_W),
        .SEED_W (SEED_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
`ifdef DECK_POOL_SEED_PORT_EN
        .seed  (seed),
`endif
        .bus   (bus)
    );

    function automatic logic [5:0] refCard(input int i);
        int k;
        logic [3:0] v;
        k = i % 27;
        if (k == 0) v = 4'd0;
        else if (k <= 24) v = 4'((k + 1) / 2);
        else if (k == 25) v = 4'd13;
        else v = 4'd14;
        return {2'(i / 27), v};
    endfunction

    function automatic rsp_t mkRsp(input logic dv, input logic de, input logic ie,
                                   input logic sd, input logic anyCard,
                                   input logic [CARD_W-1:0] card);
        rsp_t r;
        r.dv = dv; r.de = de; r.ie = ie; r.sd = sd; r.anyCard = anyCard; r.card = card;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    task automatic applyStimulus(input logic rl, input logic sh, input logic dr,
                                 input logic iv, input logic [CARD_W-1:0] card);
        bus.reload = rl; bus.shuffle = sh; bus.draw_req = dr;
        bus.insert_valid = iv; bus.insert_card = card;
        tick();
        bus.reload = 1'b0; bus.shuffle = 1'b0; bus.draw_req = 1'b0;
        bus.insert_valid = 1'b0; bus.insert_card = '0;
    endtask

    task automatic modelInit();
        model.delete();
        for (int i = 0; i < DEPTH; i++) model.push_back(refCard(i));
    endtask

    task automatic doDraw();
        if (model.size() > 0) expQ.push_back(mkRsp(1, 0, 0, 0, 0, model.pop_back()));
        else expQ.push_back(mkRsp(0, 1, 0, 0, 0, '0));
        applyStimulus(0, 0, 1, 0, '0);
    endtask

    task automatic doDrawAny();
        logic [CARD_W-1:0] dummy;
        if (model.size() > 0) dummy = model.pop_back();
        expQ.push_back(mkRsp(1, 0, 0, 0, 1, '0));
        applyStimulus(0, 0, 1, 0, '0);
    endtask

    task automatic doInsert(input logic [CARD_W-1:0] card);
        if (model.size() < DEPTH) model.push_back(card);
        else expQ.push_back(mkRsp(0, 0, 1, 0, 0, '0));
        applyStimulus(0, 0, 0, 1, card);
    endtask

    task automatic doDrawInsert(input logic [CARD_W-1:0] card);
        if (model.size() > 0) begin
            expQ.push_back(mkRsp(1, 0, 0, 0, 0, model[model.size() - 1]));
            model[model.size() - 1] = card;
        end else begin
            expQ.push_back(mkRsp(0, 1, 0, 0, 0, '0));
            model.push_back(card);
        end
        applyStimulus(0, 0, 1, 1, card);
    endtask

    task automatic waitReady(input int limit, output int cycles);
        cycles = 0;
        while (bus.ready !== 1'b1 && cycles < limit) begin
            tick();
            cycles++;
        end
    endtask

    task automatic runShuffleAndCollect();
        expQ.push_back(mkRsp(0, 0, 0, 1, 0, '0));
        applyStimulus(0, 1, 0, 0, '0);
        waitReady(1000, nCycles);
        checkOutput("shuffle_finished", bus.ready, 1);
        checkOutput("shuffle_count", bus.count, DEPTH);
        tick();
        gotCards.delete();
        for (int i = 0; i < DEPTH; i++) doDrawAny();
        tick();
        checkOutput("shuffle_drawn_total", gotCards.size(), DEPTH);
    endtask

    // Response monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && (bus.draw_valid || bus.draw_err || bus.insert_err || bus.shuffle_done)) begin
            gotRsp = mkRsp(bus.draw_valid, bus.draw_err, bus.insert_err, bus.shuffle_done,
                           1'b0, bus.draw_card);
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_rsp: got dv=%b de=%b ie=%b sd=%b card=%h, none required",
                         gotRsp.dv, gotRsp.de, gotRsp.ie, gotRsp.sd, gotRsp.card);
            end else begin
                expRsp = expQ.pop_front();
                if (expRsp.anyCard) gotCards.push_back(bus.draw_card);
                if ({gotRsp.dv, gotRsp.de, gotRsp.ie, gotRsp.sd} !==
                        {expRsp.dv, expRsp.de, expRsp.ie, expRsp.sd} ||
                    (expRsp.dv && !expRsp.anyCard && gotRsp.card !== expRsp.card)) begin
                    failures++;
                    $display("[TB] FAIL rsp: got dv=%b de=%b ie=%b sd=%b card=%h required dv=%b de=%b ie=%b sd=%b card=%h",
                             gotRsp.dv, gotRsp.de, gotRsp.ie, gotRsp.sd, gotRsp.card,
                             expRsp.dv, expRsp.de, expRsp.ie, expRsp.sd, expRsp.card);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hist [64];
        int badBins;
        int sameCnt;
        bus.reload = 1'b0; bus.shuffle = 1'b0; bus.draw_req = 1'b0;
        bus.insert_valid = 1'b0; bus.insert_card = '0;

        // Reset values
        tick(); tick();
        checkOutput("reset_ready", bus.ready, 0);
        checkOutput("reset_count", bus.count, 0);
        checkOutput("reset_empty", bus.empty, 1);
        checkOutput("reset_full", bus.full, 0);
        checkOutput("reset_draw_card", bus.draw_card, 0);
        checkOutput("reset_draw_valid", bus.draw_valid, 0);
        checkOutput("reset_shuffle_done", bus.shuffle_done, 0);

        // INIT takes exactly DEPTH cycles
        reset = 1'b0;
        repeat (DEPTH - 1) tick();
        checkOutput("init_ready_low_107", bus.ready, 0);
        tick();
        checkOutput("init_ready_108", bus.ready, 1);
        checkOutput("init_count", bus.count, DEPTH);
        checkOutput("init_full", bus.full, 1);
        checkOutput("init_empty", bus.empty, 0);
        modelInit();

        // First draw returns the last layout entry, blue WILD4
        expQ.push_back(mkRsp(1, 0, 0, 0, 0, 6'b11_1110));
        void'(model.pop_back());
        applyStimulus(0, 0, 1, 0, '0);
        checkOutput("first_draw_count", bus.count, 107);
        checkOutput("first_draw_not_full", bus.full, 0);

        // Fill, then insert on full
        doInsert(6'h15);
        checkOutput("refill_count", bus.count, DEPTH);
        doInsert(6'h05);
        checkOutput("insert_err_count", bus.count, DEPTH);

        // Drain to 5, then draw+insert together
        for (int i = 0; i < 103; i++) doDraw();
        checkOutput("drain_count5", bus.count, 5);
        doDrawInsert(6'h2A);
        checkOutput("draw_insert_count", bus.count, 5);
        doDraw();
        for (int i = 0; i < 4; i++) doDraw();
        checkOutput("drained_count", bus.count, 0);
        checkOutput("drained_empty", bus.empty, 1);
        doDraw();
        checkOutput("draw_err_count", bus.count, 0);

        // Empty pool: combined draw+insert performs the insert
        doDrawInsert(6'h33);
        checkOutput("empty_draw_insert_count", bus.count, 1);
        expQ.push_back(mkRsp(0, 0, 0, 1, 0, '0));
        applyStimulus(0, 1, 0, 0, '0);
        checkOutput("short_shuffle_ready", bus.ready, 1);
        checkOutput("short_shuffle_count", bus.count, 1);
        doDraw();

        // Reload at count 3; inputs during INIT are ignored
        doInsert(6'h01); doInsert(6'h12); doInsert(6'h23);
        checkOutput("pre_reload_count", bus.count, 3);
        applyStimulus(1, 0, 0, 0, '0);
        checkOutput("reload_ready_low", bus.ready, 0);
        checkOutput("reload_count_zero", bus.count, 0);
        applyStimulus(0, 0, 1, 0, '0);
        applyStimulus(0, 0, 0, 1, 6'h07);
        applyStimulus(0, 1, 0, 0, '0);
        repeat (104) tick();
        checkOutput("reload_ready_low_107", bus.ready, 0);
        tick();
        checkOutput("reload_ready_108", bus.ready, 1);
        checkOutput("reload_count_full", bus.count, DEPTH);
        modelInit();

        // Full shuffle: same multiset, different order
        runShuffleAndCollect();
        for (int v = 0; v < 64; v++) hist[v] = 0;
        for (int i = 0; i < DEPTH; i++) hist[refCard(i)]++;
        for (int i = 0; i < gotCards.size(); i++) hist[gotCards[i]]--;
        badBins = 0;
        for (int v = 0; v < 64; v++) if (hist[v] != 0) badBins++;
        checkOutput("shuffle_histogram_bad_bins", badBins, 0);
        sameCnt = 0;
        for (int i = 0; i < gotCards.size(); i++)
            if (gotCards[i] == refCard(DEPTH - 1 - i)) sameCnt++;
        checkOutput("shuffle_order_changed", (sameCnt != DEPTH), 1);
        firstShuffle = gotCards;

`ifdef DECK_POOL_SEED_PORT_EN
        applyStimulus(1, 0, 0, 0, '0);
        modelInit();
        waitReady(200, nCycles);
        checkOutput("rerun_ready", bus.ready, 1);
        runShuffleAndCollect();
        sameCnt = 0;
        for (int i = 0; i < DEPTH; i++)
            if (gotCards[i] === firstShuffle[i]) sameCnt++;
        checkOutput("rerun_identical", sameCnt, DEPTH);
`endif

        // Reset in the middle of SHUFFLE aborts it and re-runs INIT
        applyStimulus(1, 0, 0, 0, '0);
        modelInit();
        waitReady(200, nCycles);
        checkOutput("pre_abort_ready", bus.ready, 1);
        applyStimulus(0, 1, 0, 0, '0);
        repeat (20) tick();
        checkOutput("mid_shuffle_busy", bus.ready, 0);
        reset = 1'b1;
        #1;
        checkOutput("abort_count", bus.count, 0);
        tick(); tick();
        reset = 1'b0;
        waitReady(200, nCycles);
        checkOutput("abort_reinit_cycles", nCycles, DEPTH);
        checkOutput("abort_count_full", bus.count, DEPTH);
        modelInit();
        for (int i = 0; i < DEPTH; i++) doDraw();
        tick();
        checkOutput("final_empty", bus.empty, 1);

        checkOutput("scoreboard_pending", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/deck_pool.md
DECK_POOL -- requirements
Module: deck_pool

Interface
REQ-001 Parameter DEPTH, default 108, maximum number of cards held.
REQ-002 Parameter CARD_W, default 6, card width {color[1:0], value[CARD_W-3:0]}; must be >= 6.
REQ-003 Parameter SEED_W, default 16, LFSR width; must be >= IDX_W, where IDX_W = $clog2(DEPTH+1).
REQ-004 Ports (clock and reset first):
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- reload  in  1  pulse; restart the standard layout.
- shuffle  in  1  pulse; shuffle the current contents.
- draw_req  in  1  pop the top card.
- insert_valid  in  1  push insert_card.
- insert_card  in  CARD_W  card to push.
- ready  out  1  high only in IDLE.
- draw_valid  out  1  one-cycle pulse; draw_card is valid.
- draw_card  out  CARD_W  drawn card.
- draw_err  out  1  one-cycle pulse; draw attempted on an empty pool.
- insert_err  out  1  one-cycle pulse; insert attempted on a full pool.
- count  out  IDX_W  cards held.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- shuffle_done  out  1  one-cycle pulse at shuffle end.

Function
REQ-005 Storage: DEPTH x CARD_W array; valid entries occupy 0..count-1; the top card is entry count-1.
REQ-006 States: INIT, IDLE, SHUFFLE.
REQ-007 INIT: writes entry k = init_card(k), one entry per cycle, for k = 0..DEPTH-1.
- count becomes DEPTH in the cycle after the last write, and the state becomes IDLE.
- A DEPTH of 108 takes 108 INIT cycles.
REQ-008 IDLE with reload=1: go to INIT; count becomes 0 in the next cycle. reload has the highest priority.
REQ-009 IDLE with shuffle=1 (reload=0):
- Load the LFSR with the free-running counter value; a value of 0 is replaced by 1.
- Set j = count-1 and go to SHUFFLE.
- If count <= 1, skip SHUFFLE: pulse shuffle_done next cycle and stay in IDLE.
REQ-010 SHUFFLE, each cycle:
- Step the Galois LFSR (taps 16,14,13,11 for SEED_W=16).
- Form r = lfsr[IDX_W-1:0] & mask(j), where mask(j) is the smallest 2^n-1 that is >= j.
- r > j: reject the value; the array is unchanged.
- Otherwise: swap entries j and r, and decrement j.
- When a swap is made with j == 1: pulse shuffle_done and go to IDLE.
REQ-011 A free-running counter (SEED_W bits) increments every cycle after reset and is never cleared by reload.
REQ-012 IDLE draw_req, count > 0:
- Next cycle: draw_valid=1 with draw_card = the previous top entry.
- count decrements.
REQ-013 IDLE draw_req, count == 0: next cycle draw_err=1, draw_valid=0, no state change.
REQ-014 IDLE insert_valid, count < DEPTH: entry[count] <= insert_card, and count increments.
REQ-015 IDLE insert_valid, count == DEPTH: next cycle insert_err=1; the array is unchanged.
REQ-016 Simultaneous draw_req and insert_valid in IDLE, count > 0:
- The old top card is returned, then entry count-1 is overwritten with insert_card.
- count is unchanged; insert_err is never raised.
REQ-017 Simultaneous draw_req and insert_valid in IDLE, count == 0: the insert is performed and draw_err is pulsed.
REQ-018 When ready=0, draw_req, insert_valid, shuffle and reload are ignored silently; no err pulses are raised.
REQ-019 Simultaneous shuffle with draw/insert: the draw/insert is applied first, in the same cycle, and SHUFFLE uses the updated count.

Reset
REQ-020 reset=1 forces, asynchronously:
- state=INIT, count=0, j=0, LFSR=1, free-running counter=0.
- All pulses and draw_card = 0; ready=0; empty=1; full=0.
REQ-021 Array contents are not reset; INIT rewrites them.
REQ-022 Reset asserted mid-SHUFFLE or mid-INIT aborts the operation with no shuffle_done pulse; a full INIT follows.

Configuration
REQ-023 Macro DECK_POOL_SEED_PORT_EN.
- Defined: adds input seed[SEED_W-1:0], which replaces the free-running counter in REQ-009 (0 is still mapped to 1), giving a reproducible shuffle.
- Undefined: no seed port; the free-running counter is the seed.

Structure
REQ-024 Package deck_pkg contains:
- Color encodings: RED=0, YELLOW=1, GREEN=2, BLUE=3.
- Value encodings: 0-9, SKIP=10, REVERSE=11, DRAW2=12, WILD=13, WILD4=14.
- State enum.
- Function init_card(i), defined as follows:
  - For i < 108: color = i/27, k = i%27; k=0 -> 0; k=1..24 -> (k+1)/2; k=25 -> WILD; k=26 -> WILD4.
  - Otherwise: 0.
REQ-025 Sub-module deck_lfsr (step/load, SEED_W parameter) is instantiated once.

Verification
REQ-026 Reset, then wait 108 cycles -> ready=1, count=108, full=1; draw -> draw_card=6'b11_1110, count=107.
REQ-027 Draw 108 times, then draw again -> the 108th draw returns 6'b00_0000, empty=1; the next draw gives draw_err=1 and count stays 0.
REQ-028 Full pool, insert 6'h05 -> insert_err=1, count=108; at count=5, draw+insert 6'h2A together -> the old top is returned, entry 4 = 6'h2A, count=5.
REQ-029 With DECK_POOL_SEED_PORT_EN and seed=16'hACE1, shuffle a full pool -> shuffle_done within 1000 cycles; the per-card histogram is unchanged; the result is identical on rerun and differs from init order.
REQ-030 Reset asserted 20 cycles into SHUFFLE -> no shuffle_done; after 108 cycles the contents equal the init layout.
REQ-031 reload at count=3 -> ready=0 for 108 cycles, then count=108; draw/insert during INIT produce no response.
